// File: rtl/mt9p031_tb_pkg.sv
// Shared definitions for the MT9P031 sensor timing model: FSM states,
// default sensor geometry and the duration clamp helper.
package mt9p031_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_FRONT,
        ST_LINE,
        ST_H_BLANK,
        ST_V_BACK,
        ST_V_BLANK
    } tg_state_t;

    // Full-resolution MT9P031 geometry used when the environment does not override it
    localparam int DEF_WIDTH     = 2592;
    localparam int DEF_HEIGHT    = 1944;
    localparam int DEF_H_BLANK   = 768;
    localparam int DEF_V_FRONT   = 16;
    localparam int DEF_V_BACK    = 16;
    localparam int DEF_V_BLANK   = 8;
    localparam int DEF_FRAME_NUM = 0;

    function automatic logic [31:0] clamp1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/tg_down_cnt.sv
// Loadable down-counter; holds at zero and flags terminal count there.
module tg_down_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - WIDTH'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mt9p031_timing_ctrl.sv
// fval/lval sequencer for the MT9P031 sensor model; one shared down-counter
// is reloaded with the duration of each state as the FSM enters it.
module mt9p031_timing_ctrl
    import mt9p031_tb_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_enable,
    input  logic [CNT_WIDTH-1:0]       iv_width,
    input  logic [CNT_WIDTH-1:0]       iv_height,
    input  logic [CNT_WIDTH-1:0]       iv_h_blank,
    input  logic [CNT_WIDTH-1:0]       iv_v_front,
    input  logic [CNT_WIDTH-1:0]       iv_v_back,
    input  logic [CNT_WIDTH-1:0]       iv_v_blank,
    input  logic [FRAME_CNT_WIDTH-1:0] iv_frame_num,
    output logic                       o_fval,
    output logic                       o_lval,
    output logic [CNT_WIDTH-1:0]       ov_line_cnt,
    output logic [FRAME_CNT_WIDTH-1:0] ov_frame_cnt,
    output logic                       o_frame_done,
    output logic                       o_busy
);

    tg_state_t                state;
    logic [CNT_WIDTH-1:0]     sh_width, sh_height, sh_h_blank, sh_v_back, sh_v_blank;
    logic [FRAME_CNT_WIDTH-1:0] sh_frame_num;

    logic                 tc, ld, start, cont, last_line, enter_vf;
    logic [CNT_WIDTH-1:0] ld_val;
    logic [CNT_WIDTH:0]   next_line;

    // Counter reload value: state duration minus one, so tc marks the final cycle
    function automatic logic [CNT_WIDTH-1:0] dur(input logic [CNT_WIDTH-1:0] x);
        return CNT_WIDTH'(clamp1(32'(x)) - 32'd1);
    endfunction

    assign start     = (state == ST_IDLE) && i_enable && (iv_width != '0) && (iv_height != '0);
    assign cont      = i_enable && ((sh_frame_num == '0) || (ov_frame_cnt < sh_frame_num));
    assign next_line = {1'b0, ov_line_cnt} + (CNT_WIDTH+1)'(1);
    assign last_line = next_line >= {1'b0, sh_height};
    assign enter_vf  = start || ((state == ST_V_BLANK) && tc && cont);

    always_comb begin
        ld     = 1'b0;
        ld_val = '0;
        case (state)
            ST_IDLE: begin
                ld     = start;
                ld_val = dur(iv_v_front);
            end
            ST_V_FRONT, ST_H_BLANK: begin
                ld     = tc;
                ld_val = dur(sh_width);
            end
            ST_LINE: begin
                ld     = tc;
                ld_val = last_line ? dur(sh_v_back) : dur(sh_h_blank);
            end
            ST_V_BACK: begin
                ld     = tc;
                ld_val = dur(sh_v_blank);
            end
            ST_V_BLANK: begin
                ld     = tc && cont;
                ld_val = dur(iv_v_front);
            end
            default: begin
                ld     = 1'b0;
                ld_val = '0;
            end
        endcase
    end

    tg_down_cnt #(.WIDTH(CNT_WIDTH)) u_dur_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .tc       (tc)
    );

    // Geometry is frozen per frame; frame quota only at run start
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_width     <= '0;
            sh_height    <= '0;
            sh_h_blank   <= '0;
            sh_v_back    <= '0;
            sh_v_blank   <= '0;
            sh_frame_num <= '0;
        end else if (enter_vf) begin
            sh_width   <= iv_width;
            sh_height  <= iv_height;
            sh_h_blank <= iv_h_blank;
            sh_v_back  <= iv_v_back;
            sh_v_blank <= iv_v_blank;
            if (start)
                sh_frame_num <= iv_frame_num;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            o_fval       <= 1'b0;
            o_lval       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            ov_line_cnt  <= '0;
            ov_frame_cnt <= '0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_V_FRONT;
                        o_fval       <= 1'b1;
                        o_busy       <= 1'b1;
                        ov_line_cnt  <= '0;
                        ov_frame_cnt <= '0;
                    end
                end
                ST_V_FRONT: begin
                    if (tc) begin
                        state  <= ST_LINE;
                        o_lval <= 1'b1;
                    end
                end
                ST_LINE: begin
                    if (tc) begin
                        state       <= last_line ? ST_V_BACK : ST_H_BLANK;
                        o_lval      <= 1'b0;
                        ov_line_cnt <= ov_line_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_H_BLANK: begin
                    if (tc) begin
                        state  <= ST_LINE;
                        o_lval <= 1'b1;
                    end
                end
                ST_V_BACK: begin
                    if (tc) begin
                        state        <= ST_V_BLANK;
                        o_fval       <= 1'b0;
                        o_frame_done <= 1'b1;
                        if (ov_frame_cnt != '1)
                            ov_frame_cnt <= ov_frame_cnt + FRAME_CNT_WIDTH'(1);
                    end
                end
                ST_V_BLANK: begin
                    if (tc) begin
                        if (cont) begin
                            state       <= ST_V_FRONT;
                            o_fval      <= 1'b1;
                            ov_line_cnt <= '0;
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_fval <= 1'b0;
                    o_lval <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
